sctag_evict_dram_sched: RTL and testbench

//  Schedules the sctag DRAM address port between miss-buffer DRAM reads and WB/RDMA evict writes.

---
 rtl/sctag_evict_dram_sched.sv | 128 ++++++++++++
 tb/tb_sctag_evict_dram_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sctag_evict_dram_sched.sv
// rtl/sctag_evict_dram_sched.sv - DRAM address port scheduler: MB reads vs WB/RDMA evict writes.
// Optional perf counters enabled by defining SCTAG_EVSCHED_PERF_EN.
module sctag_evict_dram_sched #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3,
  parameter int PERF_W       = 16
) (
  input  logic              rclk,
  input  logic              arst,
  input  logic              mb_dram_rd_req,
  input  logic              wb_dram_wr_req,
  input  logic              rdma_dram_wr_req,
  input  logic              dram_sctag_ack,
  output logic              mbctl_arb_dramrd_en,
  output logic              wb_or_rdma_wr_req_en,
  output logic              wbctl_wr_addr_sel,
  output logic              sctag_dram_rd_req,
  output logic              sctag_dram_wr_req,
  output logic              mb_dram_rd_gnt,
  output logic              wb_dram_wr_gnt,
  output logic              rdma_dram_wr_gnt,
  output logic [PERF_W-1:0] perf_rd_cnt,
  output logic [PERF_W-1:0] perf_wr_cnt
);

  typedef enum logic [1:0] {IDLE, GNT, REQ, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             rr_wb;
  logic             win_rd;
  logic             win_wb;

  logic any_wr;
  logic write_due;
  logic pick_rd;
  logic pick_wb;

  always_comb begin
    any_wr    = wb_dram_wr_req | rdma_dram_wr_req;
    write_due = (starve_cnt >= CNT_W'(STARVE_LIMIT)) && any_wr;
    pick_rd   = mb_dram_rd_req && !write_due;
    // WB wins a write slot when it is alone or when the round-robin pointer favours it
    pick_wb   = wb_dram_wr_req && (!rdma_dram_wr_req || rr_wb);
  end

  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      state                <= IDLE;
      starve_cnt           <= '0;
      rr_wb                <= 1'b1;
      win_rd               <= 1'b0;
      win_wb               <= 1'b0;
      mbctl_arb_dramrd_en  <= 1'b0;
      wb_or_rdma_wr_req_en <= 1'b0;
      wbctl_wr_addr_sel    <= 1'b0;
      sctag_dram_rd_req    <= 1'b0;
      sctag_dram_wr_req    <= 1'b0;
      mb_dram_rd_gnt       <= 1'b0;
      wb_dram_wr_gnt       <= 1'b0;
      rdma_dram_wr_gnt     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mb_dram_rd_req || any_wr) begin
            state                <= GNT;
            win_rd               <= pick_rd;
            win_wb               <= !pick_rd && pick_wb;
            mbctl_arb_dramrd_en  <= pick_rd;
            wb_or_rdma_wr_req_en <= !pick_rd;
            wbctl_wr_addr_sel    <= !pick_rd && pick_wb;
            if (pick_rd) begin
              if (any_wr && (starve_cnt < CNT_W'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + CNT_W'(1);
            end else begin
              starve_cnt <= '0;
              rr_wb      <= !pick_wb;
            end
          end
        end
        GNT: begin
          mbctl_arb_dramrd_en  <= 1'b0;
          wb_or_rdma_wr_req_en <= 1'b0;
          wbctl_wr_addr_sel    <= 1'b0;
          sctag_dram_rd_req    <= win_rd;
          sctag_dram_wr_req    <= !win_rd;
          state                <= REQ;
        end
        REQ: begin
          if (dram_sctag_ack) begin
            sctag_dram_rd_req <= 1'b0;
            sctag_dram_wr_req <= 1'b0;
            mb_dram_rd_gnt    <= win_rd;
            wb_dram_wr_gnt    <= !win_rd && win_wb;
            rdma_dram_wr_gnt  <= !win_rd && !win_wb;
            state             <= DONE;
          end
        end
        DONE: begin
          // requests are deliberately not sampled here: the granted level is still stale
          mb_dram_rd_gnt   <= 1'b0;
          wb_dram_wr_gnt   <= 1'b0;
          rdma_dram_wr_gnt <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCTAG_EVSCHED_PERF_EN
  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      perf_rd_cnt <= '0;
      perf_wr_cnt <= '0;
    end else if (state == DONE) begin
      if (win_rd && (perf_rd_cnt != '1))
        perf_rd_cnt <= perf_rd_cnt + PERF_W'(1);
      if (!win_rd && (perf_wr_cnt != '1))
        perf_wr_cnt <= perf_wr_cnt + PERF_W'(1);
    end
  end
`else
  assign perf_rd_cnt = '0;
  assign perf_wr_cnt = '0;
`endif

endmodule

// File: tb/tb_sctag_evict_dram_sched.sv
// tb/tb_sctag_evict_dram_sched.sv - randomized bench for sctag_evict_dram_sched with a transaction-level model.
module tb_sctag_evict_dram_sched;

`ifdef SCTAG_EVSCHED_PERF_EN
  localparam int PW = 4;
`else
  localparam int PW = 16;
`endif
  localparam int LIMIT = 4;

  logic          rclk = 1'b0;
  logic          arst = 1'b1;
  logic          mb_dram_rd_req = 1'b0, wb_dram_wr_req = 1'b0, rdma_dram_wr_req = 1'b0, dram_sctag_ack = 1'b0;
  logic          mbctl_arb_dramrd_en, wb_or_rdma_wr_req_en, wbctl_wr_addr_sel;
  logic          sctag_dram_rd_req, sctag_dram_wr_req;
  logic          mb_dram_rd_gnt, wb_dram_wr_gnt, rdma_dram_wr_gnt;
  logic [PW-1:0] perf_rd_cnt, perf_wr_cnt;

  sctag_evict_dram_sched #(.STARVE_LIMIT(LIMIT), .CNT_W(3), .PERF_W(PW)) dut (
    .rclk(rclk), .arst(arst),
    .mb_dram_rd_req(mb_dram_rd_req), .wb_dram_wr_req(wb_dram_wr_req),
    .rdma_dram_wr_req(rdma_dram_wr_req), .dram_sctag_ack(dram_sctag_ack),
    .mbctl_arb_dramrd_en(mbctl_arb_dramrd_en), .wb_or_rdma_wr_req_en(wb_or_rdma_wr_req_en),
    .wbctl_wr_addr_sel(wbctl_wr_addr_sel), .sctag_dram_rd_req(sctag_dram_rd_req),
    .sctag_dram_wr_req(sctag_dram_wr_req), .mb_dram_rd_gnt(mb_dram_rd_gnt),
    .wb_dram_wr_gnt(wb_dram_wr_gnt), .rdma_dram_wr_gnt(rdma_dram_wr_gnt),
    .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt)
  );

  always #5 rclk = ~rclk;

  int compared = 0;
  int mismatched = 0;

  // model state: requester 0 = MB read, 1 = WB write, 2 = RDMA write
  int  cyc = 0;
  bit  pend [3];
  int  prob [3];
  int  dly_min, dly_max;
  bit  spur;
  bit  in_txn;
  int  a, k, win;
  int  starve;
  bit  rr_wb;
  int  n_rd, n_wr;
  int  dut_log[$];

  function automatic logic [PW-1:0] psat(int n);
`ifdef SCTAG_EVSCHED_PERF_EN
    int mx = (1 << PW) - 1;
    return (n > mx) ? PW'(mx) : PW'(n);
`else
    return '0;
`endif
  endfunction

  task automatic arbitrate();
    bit wr_any = pend[1] | pend[2];
    bit due    = (starve >= LIMIT) && wr_any;
    if (pend[0] && !due) begin
      win = 0;
      if (wr_any && starve < LIMIT) starve = starve + 1;
    end else begin
      if (pend[1] && pend[2]) win = rr_wb ? 1 : 2;
      else                    win = pend[1] ? 1 : 2;
      starve = 0;
      rr_wb  = (win == 2);
    end
    a      = cyc;
    k      = cyc + 2 + $urandom_range(dly_max, dly_min);
    in_txn = 1;
  endtask

  task automatic step();
    logic [7:0] exp_v, act_v;
    for (int i = 0; i < 3; i++)
      if (!pend[i] && ($urandom_range(99) < prob[i])) pend[i] = 1;
    mb_dram_rd_req   = pend[0];
    wb_dram_wr_req   = pend[1];
    rdma_dram_wr_req = pend[2];
    if (!in_txn && (pend[0] || pend[1] || pend[2])) arbitrate();
    if (in_txn && cyc >= a + 2 && cyc <= k) dram_sctag_ack = (cyc == k);
    else dram_sctag_ack = spur && ($urandom_range(3) == 0);
    @(negedge rclk);
    exp_v[7] = in_txn && cyc == a + 1 && win == 0;
    exp_v[6] = in_txn && cyc == a + 1 && win != 0;
    exp_v[5] = in_txn && cyc == a + 1 && win == 1;
    exp_v[4] = in_txn && cyc >= a + 2 && cyc <= k && win == 0;
    exp_v[3] = in_txn && cyc >= a + 2 && cyc <= k && win != 0;
    exp_v[2] = in_txn && cyc == k + 1 && win == 0;
    exp_v[1] = in_txn && cyc == k + 1 && win == 1;
    exp_v[0] = in_txn && cyc == k + 1 && win == 2;
    act_v = {mbctl_arb_dramrd_en, wb_or_rdma_wr_req_en, wbctl_wr_addr_sel, sctag_dram_rd_req,
             sctag_dram_wr_req, mb_dram_rd_gnt, wb_dram_wr_gnt, rdma_dram_wr_gnt};
    compared++;
    if ({act_v, perf_rd_cnt, perf_wr_cnt} !== {exp_v, psat(n_rd), psat(n_wr)}) begin
      mismatched++;
      $display("FAIL outputs cycle %0d: got en/sel/req/gnt=%b perf_rd=%0d perf_wr=%0d, expected %b %0d %0d",
               cyc, act_v, perf_rd_cnt, perf_wr_cnt, exp_v, psat(n_rd), psat(n_wr));
    end
    if (mb_dram_rd_gnt)   dut_log.push_back(0);
    if (wb_dram_wr_gnt)   dut_log.push_back(1);
    if (rdma_dram_wr_gnt) dut_log.push_back(2);
    @(posedge rclk);
    #1;
    if (in_txn && cyc == k + 1) begin
      pend[win] = 0;
      if (win == 0) n_rd++; else n_wr++;
      in_txn = 0;
    end
    cyc++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // called one time unit after a rising edge; arst takes effect asynchronously
  task automatic do_reset(bit clear_pend);
    logic [7:0] act_v;
    arst = 1'b1;
    #1;
    act_v = {mbctl_arb_dramrd_en, wb_or_rdma_wr_req_en, wbctl_wr_addr_sel, sctag_dram_rd_req,
             sctag_dram_wr_req, mb_dram_rd_gnt, wb_dram_wr_gnt, rdma_dram_wr_gnt};
    compared++;
    if ({act_v, perf_rd_cnt, perf_wr_cnt} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b perf_rd=%0d perf_wr=%0d, expected all zero",
               act_v, perf_rd_cnt, perf_wr_cnt);
    end
    @(posedge rclk);
    #1;
    arst = 1'b0;
    if (clear_pend) for (int i = 0; i < 3; i++) pend[i] = 0;
    in_txn = 0; starve = 0; rr_wb = 1; n_rd = 0; n_wr = 0;
    dram_sctag_ack = 1'b0;
    cyc++;
    dut_log.delete();
  endtask

  task automatic check_log(string name, int exp_q[$]);
    for (int i = 0; i < exp_q.size(); i++) begin
      compared++;
      if (i >= dut_log.size()) begin
        mismatched++;
        $display("FAIL %s grant %0d: got no grant, expected source %0d", name, i, exp_q[i]);
      end else if (dut_log[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL %s grant %0d: got source %0d, expected source %0d", name, i, dut_log[i], exp_q[i]);
      end
    end
  endtask

  task automatic set_cfg(int p0, int p1, int p2, int dmin, int dmax, bit s);
    prob[0] = p0; prob[1] = p1; prob[2] = p2;
    dly_min = dmin; dly_max = dmax; spur = s;
  endtask

  task automatic test_reset();
    set_cfg(0, 0, 0, 0, 0, 0);
    do_reset(1);
    run(3);
  endtask

  task automatic test_single_read();
    set_cfg(100, 0, 0, 2, 2, 0);
    do_reset(1);
    run(12);
    check_log("single_read", '{0, 0});
  endtask

  task automatic test_rr_writes();
    set_cfg(0, 100, 100, 0, 0, 0);
    do_reset(1);
    run(25);
    check_log("rr_writes", '{1, 2, 1, 2, 1});
  endtask

  task automatic test_starvation();
    set_cfg(100, 100, 100, 1, 1, 0);
    do_reset(1);
    run(55);
    check_log("starvation", '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2});
  endtask

  task automatic test_reset_mid();
    int n = 0;
    set_cfg(100, 0, 0, 6, 6, 0);
    do_reset(1);
    while (!(in_txn && cyc >= a + 3) && n < 20) begin
      step();
      n++;
    end
    compared++;
    if (!(in_txn && cyc >= a + 3)) begin
      mismatched++;
      $display("FAIL reset_mid_reach: got no REQ phase within %0d cycles, expected one", n);
    end
    do_reset(0);
    run(14);
    check_log("reset_mid_regrant", '{0});
  endtask

  task automatic test_spurious_ack();
    set_cfg(30, 30, 30, 0, 3, 1);
    do_reset(1);
    run(300);
  endtask

  task automatic test_random();
    set_cfg(60, 40, 40, 0, 4, 1);
    do_reset(1);
    run(1500);
  endtask

  task automatic test_perf();
    set_cfg(100, 0, 0, 0, 0, 0);
    do_reset(1);
    run(90);
    compared++;
`ifdef SCTAG_EVSCHED_PERF_EN
    if (perf_rd_cnt !== PW'(15)) begin
`else
    if (perf_rd_cnt !== PW'(0)) begin
`endif
      mismatched++;
      $display("FAIL perf_saturate: got perf_rd_cnt=%0d after %0d reads", perf_rd_cnt, n_rd);
    end
  endtask

  initial begin
    @(posedge rclk);
    #1;
    test_reset();
    test_single_read();
    test_rr_writes();
    test_starvation();
    test_reset_mid();
    test_spurious_ack();
    test_random();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
